// File: rtl/eth_mac_tx_ptp_arb.sv
// Frame-granular round-robin arbiter in front of one MAC TX path: one PTP tag per granted frame,
// then the frame itself; returned timestamps are steered back to the port encoded in the tag's upper bits.
module eth_mac_tx_ptp_arb #(
    parameter int PORTS         = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH/8,
    parameter int PTP_TS_WIDTH  = 96,
    parameter int PTP_TAG_WIDTH = 16,
    localparam int CL_PORTS       = $clog2(PORTS),
    localparam int USER_TAG_WIDTH = PTP_TAG_WIDTH - CL_PORTS
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic [PORTS-1:0]                 s_axis_tvalid,
    output logic [PORTS-1:0]                 s_axis_tready,
    input  logic [PORTS-1:0]                 s_axis_tlast,
    input  logic [PORTS-1:0]                 s_axis_tuser,
    input  logic [PORTS*USER_TAG_WIDTH-1:0]  s_axis_tag,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,

    output logic [PTP_TAG_WIDTH-1:0]         m_axis_ptp_tag,
    output logic                             m_axis_ptp_tag_valid,
    input  logic                             m_axis_ptp_tag_ready,

    input  logic [PTP_TS_WIDTH-1:0]          s_axis_ptp_ts_96,
    input  logic [PTP_TAG_WIDTH-1:0]         s_axis_ptp_ts_tag,
    input  logic                             s_axis_ptp_ts_valid,
    output logic                             s_axis_ptp_ts_ready,

    output logic [PORTS*PTP_TS_WIDTH-1:0]    m_axis_ptp_ts_96,
    output logic [PORTS*USER_TAG_WIDTH-1:0]  m_axis_ptp_ts_tag,
    output logic [PORTS-1:0]                 m_axis_ptp_ts_valid,
    input  logic [PORTS-1:0]                 m_axis_ptp_ts_ready,

    output logic [1:0]                       dbg_state_o,
    output logic [CL_PORTS-1:0]              dbg_rr_ptr_o
);

    // All streams use valid/ready: a transfer happens on a rising clk edge where both are high;
    // a source holds its payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [CL_PORTS-1:0] LAST_PORT = CL_PORTS'(PORTS-1);

    state_t                     state_q, state_d;
    logic [CL_PORTS-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CL_PORTS-1:0]        grant_q, grant_d;
    logic [PTP_TAG_WIDTH-1:0]   tag_q, tag_d;

    logic                       req_any;
    logic [CL_PORTS-1:0]        arb_idx;
    logic [CL_PORTS-1:0]        ts_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            tag_q    <= tag_d;
        end
    end

    // Search outward from rr_ptr, wrapping at PORTS rather than at a power of two.
    always_comb begin
        int idx;
        req_any = 1'b0;
        arb_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!req_any && s_axis_tvalid[idx]) begin
                req_any = 1'b1;
                arb_idx = CL_PORTS'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        tag_d    = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d = arb_idx;
                    tag_d   = {arb_idx, s_axis_tag[int'(arb_idx)*USER_TAG_WIDTH +: USER_TAG_WIDTH]};
                    state_d = ST_TAG;
                end
            end
            ST_TAG: begin
                if (m_axis_ptp_tag_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    rr_ptr_d = (grant_q == LAST_PORT) ? '0 : grant_q + CL_PORTS'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_ptp_tag       = tag_q;
        m_axis_ptp_tag_valid = (state_q == ST_TAG);
        m_axis_tdata         = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep         = s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast         = s_axis_tlast[grant_q];
        m_axis_tuser         = s_axis_tuser[grant_q];
        m_axis_tvalid        = 1'b0;
        s_axis_tready        = '0;
        if (state_q == ST_DATA) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    // Return path: entries tagged with a non-existent port are acknowledged and dropped.
    assign ts_port = s_axis_ptp_ts_tag[PTP_TAG_WIDTH-1 -: CL_PORTS];

    always_comb begin
        m_axis_ptp_ts_valid = '0;
        s_axis_ptp_ts_ready = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
            if (ts_port == CL_PORTS'(i)) begin
                m_axis_ptp_ts_valid[i] = s_axis_ptp_ts_valid;
                s_axis_ptp_ts_ready    = m_axis_ptp_ts_ready[i];
            end
        end
    end

    assign m_axis_ptp_ts_96  = {PORTS{s_axis_ptp_ts_96}};
    assign m_axis_ptp_ts_tag = {PORTS{s_axis_ptp_ts_tag[USER_TAG_WIDTH-1:0]}};

    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_eth_mac_tx_ptp_arb.sv
// Bench for eth_mac_tx_ptp_arb: return-path vector table, hand sequences for tag backpressure
// and mid-frame reset, and randomized multi-port traffic against a queue-based rotation model.
module tb_eth_mac_tx_ptp_arb;

  localparam int P   = 2;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int TSW = 96;
  localparam int TGW = 16;
  localparam int CLP = 1;
  localparam int UTW = 15;
  localparam int BW  = DW + KW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (PORTS=2) ----------------
  logic [P*DW-1:0]   s_axis_tdata = '0;
  logic [P*KW-1:0]   s_axis_tkeep = '0;
  logic [P-1:0]      s_axis_tvalid = '0;
  logic [P-1:0]      s_axis_tready;
  logic [P-1:0]      s_axis_tlast = '0;
  logic [P-1:0]      s_axis_tuser = '0;
  logic [P*UTW-1:0]  s_axis_tag = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [TGW-1:0]    m_axis_ptp_tag;
  logic              m_axis_ptp_tag_valid;
  logic              m_axis_ptp_tag_ready = 1'b0;
  logic [TSW-1:0]    s_axis_ptp_ts_96 = '0;
  logic [TGW-1:0]    s_axis_ptp_ts_tag = '0;
  logic              s_axis_ptp_ts_valid = 1'b0;
  logic              s_axis_ptp_ts_ready;
  logic [P*TSW-1:0]  m_axis_ptp_ts_96;
  logic [P*UTW-1:0]  m_axis_ptp_ts_tag;
  logic [P-1:0]      m_axis_ptp_ts_valid;
  logic [P-1:0]      m_axis_ptp_ts_ready = '0;
  logic [1:0]        dbg_state;
  logic [CLP-1:0]    dbg_rr_ptr;

  eth_mac_tx_ptp_arb #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                       .PTP_TS_WIDTH(TSW), .PTP_TAG_WIDTH(TGW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tag(s_axis_tag),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_ptp_tag(m_axis_ptp_tag), .m_axis_ptp_tag_valid(m_axis_ptp_tag_valid),
    .m_axis_ptp_tag_ready(m_axis_ptp_tag_ready),
    .s_axis_ptp_ts_96(s_axis_ptp_ts_96), .s_axis_ptp_ts_tag(s_axis_ptp_ts_tag),
    .s_axis_ptp_ts_valid(s_axis_ptp_ts_valid), .s_axis_ptp_ts_ready(s_axis_ptp_ts_ready),
    .m_axis_ptp_ts_96(m_axis_ptp_ts_96), .m_axis_ptp_ts_tag(m_axis_ptp_ts_tag),
    .m_axis_ptp_ts_valid(m_axis_ptp_ts_valid), .m_axis_ptp_ts_ready(m_axis_ptp_ts_ready),
    .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  // ---------------- DUT (PORTS=3), return path only ----------------
  logic [3*DW-1:0]   s3_tdata = '0;
  logic [3*KW-1:0]   s3_tkeep = '0;
  logic [2:0]        s3_tvalid = '0;
  logic [2:0]        s3_tready;
  logic [2:0]        s3_tlast = '0;
  logic [2:0]        s3_tuser = '0;
  logic [3*14-1:0]   s3_tag = '0;
  logic [DW-1:0]     m3_tdata;
  logic [KW-1:0]     m3_tkeep;
  logic              m3_tvalid, m3_tlast, m3_tuser;
  logic [TGW-1:0]    m3_ptp_tag;
  logic              m3_ptp_tag_valid;
  logic [TGW-1:0]    s3_ts_tag = '0;
  logic              s3_ts_valid = 1'b0;
  logic              s3_ts_ready;
  logic [3*TSW-1:0]  m3_ts_96;
  logic [3*14-1:0]   m3_ts_tag;
  logic [2:0]        m3_ts_valid;
  logic [2:0]        m3_ts_ready = '0;
  logic [1:0]        dbg3_state;
  logic [1:0]        dbg3_rr_ptr;

  eth_mac_tx_ptp_arb #(.PORTS(3), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                       .PTP_TS_WIDTH(TSW), .PTP_TAG_WIDTH(TGW)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s3_tdata), .s_axis_tkeep(s3_tkeep),
    .s_axis_tvalid(s3_tvalid), .s_axis_tready(s3_tready),
    .s_axis_tlast(s3_tlast), .s_axis_tuser(s3_tuser), .s_axis_tag(s3_tag),
    .m_axis_tdata(m3_tdata), .m_axis_tkeep(m3_tkeep),
    .m_axis_tvalid(m3_tvalid), .m_axis_tready(1'b1),
    .m_axis_tlast(m3_tlast), .m_axis_tuser(m3_tuser),
    .m_axis_ptp_tag(m3_ptp_tag), .m_axis_ptp_tag_valid(m3_ptp_tag_valid),
    .m_axis_ptp_tag_ready(1'b1),
    .s_axis_ptp_ts_96(s_axis_ptp_ts_96), .s_axis_ptp_ts_tag(s3_ts_tag),
    .s_axis_ptp_ts_valid(s3_ts_valid), .s_axis_ptp_ts_ready(s3_ts_ready),
    .m_axis_ptp_ts_96(m3_ts_96), .m_axis_ptp_ts_tag(m3_ts_tag),
    .m_axis_ptp_ts_valid(m3_ts_valid), .m_axis_ptp_ts_ready(m3_ts_ready),
    .dbg_state_o(dbg3_state), .dbg_rr_ptr_o(dbg3_rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int model_rr = 0;
  logic [BW-1:0]  exp_q[$];
  logic [BW-1:0]  src_q[P][$];
  logic [UTW-1:0] tagsrc_q[P][$];
  bit             at_start[P];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int p, input int n, input logic [UTW-1:0] t);
    logic [BW-1:0] b;
    for (int i = 0; i < n; i++) begin
      b[BW-1 -: DW] = $urandom;
      b[KW+1:2]     = (i == n-1) ? KW'($urandom_range(1, 15)) : {KW{1'b1}};
      b[1]          = (i == n-1);
      b[0]          = (i == n-1) ? 1'($urandom_range(0, 1)) : 1'b0;
      src_q[p].push_back(b);
    end
    tagsrc_q[p].push_back(t);
  endtask

  task automatic drive_all(input bit rnd);
    logic [BW-1:0] b;
    for (int p = 0; p < P; p++) begin
      if (src_q[p].size() > 0 && (at_start[p] || !rnd || $urandom_range(0, 3) != 0)) begin
        b = src_q[p][0];
        s_axis_tvalid[p]            = 1'b1;
        s_axis_tdata[p*DW +: DW]    = b[BW-1 -: DW];
        s_axis_tkeep[p*KW +: KW]    = b[KW+1:2];
        s_axis_tlast[p]             = b[1];
        s_axis_tuser[p]             = b[0];
      end else begin
        s_axis_tvalid[p] = 1'b0;
      end
      if (tagsrc_q[p].size() > 0) s_axis_tag[p*UTW +: UTW] = tagsrc_q[p][0];
    end
    m_axis_tready        = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_axis_ptp_tag_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  // Reference: grants rotate from model_rr over ports with frames still awaiting a grant;
  // each grant emits one tag then that port's next whole frame.
  task automatic run_traffic(input bit rnd, input int rst_at_beat, input int budget);
    int cyc = 0, gp = 0, beats = 0, idle = 0, cand;
    bit after_last = 1'b0, hs[P], busy, aborted = 1'b0;
    logic [BW-1:0] got, exp;
    for (int p = 0; p < P; p++) at_start[p] = 1'b1;
    @(posedge clk); #1;
    drive_all(rnd);
    busy = 1'b1;
    while (busy && cyc < budget) begin
      @(negedge clk);
      for (int p = 0; p < P; p++) hs[p] = s_axis_tvalid[p] && s_axis_tready[p];
      if (m_axis_ptp_tag_valid && m_axis_ptp_tag_ready) begin
        gp = -1;
        for (int i = 0; i < P; i++) begin
          cand = (model_rr + i) % P;
          if (gp < 0 && tagsrc_q[cand].size() > 0) gp = cand;
        end
        if (gp < 0) begin
          check("tag_unexpected", 1'b1, 1'b0);
        end else begin
          check("ptp_tag", m_axis_ptp_tag, {CLP'(gp), tagsrc_q[gp][0]});
          void'(tagsrc_q[gp].pop_front());
          for (int i = 0; i < src_q[gp].size(); i++) begin
            exp_q.push_back(src_q[gp][i]);
            if (src_q[gp][i][1]) break;
          end
        end
      end
      if (rst_at_beat >= 0 && beats == rst_at_beat && m_axis_tvalid) begin
        rst = 1'b1;
        aborted = 1'b1;
        busy = 1'b0;
      end else if (m_axis_tvalid && m_axis_tready) begin
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (exp_q.size() == 0) begin
          check("beat_unexpected", got, '0);
        end else begin
          exp = exp_q.pop_front();
          check("m_beat", got, exp);
        end
        if (!rnd && after_last) check("frame_gap", idle, 2);
        after_last = m_axis_tlast;
        idle = 0;
        beats++;
        if (m_axis_tlast) model_rr = (gp + 1) % P;
      end else begin
        idle++;
      end
      @(posedge clk); #1;
      if (aborted) begin
        rst = 1'b0;
        break;
      end
      for (int p = 0; p < P; p++) begin
        if (hs[p]) at_start[p] = src_q[p].pop_front() [1];
      end
      drive_all(rnd);
      busy = (exp_q.size() > 0);
      for (int p = 0; p < P; p++) if (src_q[p].size() > 0) busy = 1'b1;
      cyc++;
    end
    if (cyc >= budget) check("traffic_timeout", cyc, 0);
    if (aborted) begin
      model_rr = 0;
      exp_q.delete();
      for (int p = 0; p < P; p++) begin
        src_q[p].delete();
        tagsrc_q[p].delete();
      end
    end
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    m_axis_ptp_tag_ready = 1'b0;
  endtask

  // ---------------- return-path vector table ----------------
  typedef struct {
    bit          use3;
    logic [15:0] tag;
    logic        v;
    logic [2:0]  mr;
    logic [2:0]  ev;
    logic        er;
    logic [14:0] eu;
  } rv_t;
  rv_t rv[13];

  initial begin
    logic [TSW-1:0] ts;
    logic [127:0]   act;

    rv[0]  = '{1'b0, 16'h0042, 1'b1, 3'b000, 3'b001, 1'b0, 15'h0042};
    rv[1]  = '{1'b0, 16'h0042, 1'b1, 3'b001, 3'b001, 1'b1, 15'h0042};
    rv[2]  = '{1'b0, 16'h0042, 1'b1, 3'b010, 3'b001, 1'b0, 15'h0042};
    rv[3]  = '{1'b0, 16'h8042, 1'b1, 3'b010, 3'b010, 1'b1, 15'h0042};
    rv[4]  = '{1'b0, 16'h8042, 1'b1, 3'b001, 3'b010, 1'b0, 15'h0042};
    rv[5]  = '{1'b0, 16'h0042, 1'b0, 3'b001, 3'b000, 1'b1, 15'h0042};
    rv[6]  = '{1'b0, 16'h7abc, 1'b0, 3'b000, 3'b000, 1'b0, 15'h7abc};
    rv[7]  = '{1'b1, 16'hC005, 1'b1, 3'b000, 3'b000, 1'b1, 15'h0005};
    rv[8]  = '{1'b1, 16'hC005, 1'b1, 3'b111, 3'b000, 1'b1, 15'h0005};
    rv[9]  = '{1'b1, 16'h8005, 1'b1, 3'b100, 3'b100, 1'b1, 15'h0005};
    rv[10] = '{1'b1, 16'h8005, 1'b1, 3'b011, 3'b100, 1'b0, 15'h0005};
    rv[11] = '{1'b1, 16'h4abc, 1'b1, 3'b010, 3'b010, 1'b1, 15'h0abc};
    rv[12] = '{1'b1, 16'h0005, 1'b1, 3'b001, 3'b001, 1'b1, 15'h0005};

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {dbg_state, dbg_rr_ptr, m_axis_tvalid, m_axis_ptp_tag_valid, s_axis_tready},
          {2'd0, 1'b0, 1'b0, 1'b0, 2'b00});

    // timestamp return routing
    for (int i = 0; i < 13; i++) begin
      ts = (i == 0) ? 96'h1_0000_0000_0000_0005 : {$urandom, $urandom, $urandom};
      s_axis_ptp_ts_96 = ts;
      if (!rv[i].use3) begin
        s_axis_ptp_ts_tag = rv[i].tag; s_axis_ptp_ts_valid = rv[i].v; m_axis_ptp_ts_ready = rv[i].mr[1:0];
        #1;
        act = {1'b0, m_axis_ptp_ts_valid, s_axis_ptp_ts_ready, m_axis_ptp_ts_tag[14:0]};
        check($sformatf("ret2_vec%0d", i), act, {rv[i].ev, rv[i].er, rv[i].eu});
        check("ret2_bcast", {m_axis_ptp_ts_96, m_axis_ptp_ts_tag[29:15]}, {ts, ts, rv[i].eu});
      end else begin
        s3_ts_tag = rv[i].tag; s3_ts_valid = rv[i].v; m3_ts_ready = rv[i].mr;
        #1;
        act = {m3_ts_valid, s3_ts_ready, 1'b0, m3_ts_tag[13:0]};
        check($sformatf("ret3_vec%0d", i), act, {rv[i].ev, rv[i].er, rv[i].eu});
        check("ret3_bcast", {m3_ts_96[TSW-1:0], m3_ts_96[3*TSW-1 -: TSW], m3_ts_tag[41:28]},
              {ts, ts, rv[i].eu[13:0]});
      end
    end
    s_axis_ptp_ts_valid = 1'b0;
    s3_ts_valid = 1'b0;

    // single port 1, 64-byte frame, tag 0x123, tag ready held low for 5 cycles
    @(posedge clk); #1;
    s_axis_tvalid = 2'b10;
    s_axis_tdata[63:32] = 32'hA500_0000;
    s_axis_tkeep[7:4] = 4'hF;
    s_axis_tlast[1] = 1'b0;
    s_axis_tuser[1] = 1'b0;
    s_axis_tag[29:15] = 15'h123;
    m_axis_tready = 1'b1;
    m_axis_ptp_tag_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("tag_hold", {m_axis_ptp_tag_valid, m_axis_ptp_tag, m_axis_tvalid}, {1'b1, 16'h8123, 1'b0});
    end
    m_axis_ptp_tag_ready = 1'b1;
    @(posedge clk); #1;
    m_axis_ptp_tag_ready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      check($sformatf("sp_beat%0d", b),
            {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_ptp_tag_valid, s_axis_tready},
            {1'b1, 32'hA500_0000 | b, (b == 15), 1'b0, 2'b10});
      @(posedge clk); #1;
      s_axis_tdata[63:32] = 32'hA500_0000 | (b + 1);
      s_axis_tlast[1] = (b + 1 == 15);
      if (b == 15) s_axis_tvalid = 2'b00;
    end
    m_axis_tready = 1'b0;
    @(negedge clk);
    check("sp_after", {dbg_state, dbg_rr_ptr, m_axis_ptp_tag_valid}, {2'd0, 1'b0, 1'b0});
    model_rr = 0;

    // round robin, continuous traffic on both ports, no backpressure
    for (int f = 0; f < 4; f++) begin
      push_frame(0, $urandom_range(1, 6), UTW'($urandom));
      push_frame(1, $urandom_range(1, 6), UTW'($urandom));
    end
    run_traffic(1'b0, -1, 2000);

    // randomized traffic with gaps and backpressure
    for (int f = 0; f < 6; f++) push_frame(0, $urandom_range(1, 8), UTW'($urandom));
    for (int f = 0; f < 4; f++) push_frame(1, $urandom_range(1, 8), UTW'($urandom));
    run_traffic(1'b1, -1, 5000);
    @(negedge clk);
    check("rand_rr_ptr", dbg_rr_ptr, model_rr);

    // reset mid-frame
    push_frame(0, 2, 15'h0011);
    run_traffic(1'b0, -1, 200);
    @(negedge clk);
    check("pre_rst_rr", dbg_rr_ptr, 1'b1);
    push_frame(1, 8, 15'h0022);
    run_traffic(1'b0, 4, 200);
    @(negedge clk);
    check("post_rst", {dbg_state, dbg_rr_ptr, m_axis_tvalid, m_axis_ptp_tag_valid}, {2'd0, 1'b0, 1'b0, 1'b0});
    push_frame(0, 3, 15'h0033);
    push_frame(1, 3, 15'h0044);
    run_traffic(1'b0, -1, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
